mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_bus_arbiter_if.sv | 52 +++++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 19 +
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-master memory bus arbiter
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NUM_MASTERS = 2;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Round-robin pointer after a completion: favour whichever master was not just served.
  function automatic logic next_ptr(input logic [1:0] served);
    return served[0];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - two request ports plus one shared slave port
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              m0_valid;
  logic              m0_instr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [STRB_W-1:0] m0_wstrb;
  logic              m0_ready;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_valid;
  logic              m1_instr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [STRB_W-1:0] m1_wstrb;
  logic              m1_ready;
  logic [DATA_W-1:0] m1_rdata;

  logic              s_valid;
  logic              s_instr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_ready;
  logic [DATA_W-1:0] s_rdata;

  // Arbiter's view: it serves both masters and drives the shared slave request.
  modport slave (
    input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata,
    output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  // Environment's view: the two masters and the memory behind the arbiter.
  modport master (
    output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata,
    input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// rtl/mem_bus_arbiter_rr_arbiter2.sv - two-way round-robin priority select
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // A lone requester always wins; on contention the pointer picks the winner.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master to one-slave memory bus arbiter with wait timeout
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              TIMEOUT  = 256,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus,
  output logic [1:0]         grant,
  output logic               timeout_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         grant_q;
  logic               ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         arb_gnt;
  logic               busy;
  logic               timeout_hit;
  logic               done;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;
  logic               sel_instr;
  logic [DATA_W-1:0]  ret_data;

  rr_arbiter2 u_rr (
    .req ({bus.m1_valid, bus.m0_valid}),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  assign busy        = (state_q == BUSY);
  // A same-cycle s_ready beats the timeout, so the real data wins.
  assign timeout_hit = busy && !bus.s_ready && (cnt_q == CNT_LAST);
  assign done        = busy && (bus.s_ready || timeout_hit);
  assign grant       = grant_q;
  assign timeout_err = timeout_hit;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: start on any request, finish on slave ready or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_gnt != 2'b00) state_d = BUSY;
      BUSY:    if (done)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, round-robin pointer and wait counter; requests dropping mid-transfer are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      grant_q <= arb_gnt;
      cnt_q   <= '0;
    end else if (done) begin
      grant_q <= 2'b00;
      ptr_q   <= next_ptr(grant_q);
      cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Request mux from the owning master.
  always_comb begin
    sel_addr  = bus.m0_addr;
    sel_wdata = bus.m0_wdata;
    sel_wstrb = bus.m0_wstrb;
    sel_instr = bus.m0_instr;
    if (grant_q[1]) begin
      sel_addr  = bus.m1_addr;
      sel_wdata = bus.m1_wdata;
      sel_wstrb = bus.m1_wstrb;
      sel_instr = bus.m1_instr;
    end
  end

  // Outputs: slave request mirrors the owner while BUSY, everything zero otherwise.
  always_comb begin
    bus.s_valid  = 1'b0;
    bus.s_instr  = 1'b0;
    bus.s_addr   = '0;
    bus.s_wdata  = '0;
    bus.s_wstrb  = '0;
    bus.m0_ready = 1'b0;
    bus.m1_ready = 1'b0;
    bus.m0_rdata = '0;
    bus.m1_rdata = '0;
    ret_data     = timeout_hit ? ERR_DATA : bus.s_rdata;
    if (busy) begin
      bus.s_valid = 1'b1;
      bus.s_instr = sel_instr;
      bus.s_addr  = sel_addr;
      bus.s_wdata = sel_wdata;
      bus.s_wstrb = sel_wstrb;
      if (grant_q[0]) begin
        bus.m0_ready = done;
        bus.m0_rdata = ret_data;
      end
      if (grant_q[1]) begin
        bus.m1_ready = done;
        bus.m1_rdata = ret_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       timeout_err;
  int         passed = 0;
  int         total  = 0;
  int         fails  = 0;
  logic [1:0] exp_order [4];

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m0_valid = 0; bus.m0_instr = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_wstrb = 0;
    bus.m1_valid = 0; bus.m1_instr = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
    bus.s_ready = 0; bus.s_rdata = 0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_s_valid", {31'd0, bus.s_valid}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_m0_ready", {31'd0, bus.m0_ready}, 32'd0);
    reset = 1'b0;

    // m0 read alone, slave answers on the third BUSY cycle
    bus.m0_valid = 1; bus.m0_addr = 32'h100; bus.m0_wstrb = 4'h0;
    #1;
    chk("idle_s_valid", {31'd0, bus.s_valid}, 32'd0);
    chk("idle_s_addr", bus.s_addr, 32'd0);
    tick();
    chk("rd_grant", {30'd0, grant}, 32'd1);
    chk("rd_s_valid", {31'd0, bus.s_valid}, 32'd1);
    chk("rd_s_addr", bus.s_addr, 32'h100);
    chk("rd_m0_ready_wait", {31'd0, bus.m0_ready}, 32'd0);
    tick();
    chk("rd_m0_ready_wait2", {31'd0, bus.m0_ready}, 32'd0);
    tick();
    bus.s_ready = 1; bus.s_rdata = 32'h12345678;
    #1;
    chk("rd_m0_ready", {31'd0, bus.m0_ready}, 32'd1);
    chk("rd_m0_rdata", bus.m0_rdata, 32'h12345678);
    chk("rd_m1_ready", {31'd0, bus.m1_ready}, 32'd0);
    chk("rd_m1_rdata", bus.m1_rdata, 32'd0);
    bus.m0_valid = 0;
    tick();
    bus.s_ready = 0;
    #1;
    chk("rd_done_grant", {30'd0, grant}, 32'd0);
    chk("rd_done_m0_ready", {31'd0, bus.m0_ready}, 32'd0);

    // Fresh reset, then both masters contend for four back-to-back transfers
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    bus.m0_valid = 1; bus.m0_addr = 32'h200;
    bus.m1_valid = 1; bus.m1_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_grant_%0d", i), {30'd0, grant}, {30'd0, exp_order[i]});
      chk($sformatf("rr_addr_%0d", i), bus.s_addr, exp_order[i][0] ? 32'h200 : 32'h300);
      bus.s_ready = 1; bus.s_rdata = 32'h1000 + i;
      #1;
      chk($sformatf("rr_m0_ready_%0d", i), {31'd0, bus.m0_ready}, {31'd0, exp_order[i][0]});
      chk($sformatf("rr_m1_ready_%0d", i), {31'd0, bus.m1_ready}, {31'd0, exp_order[i][1]});
      if (i == 3) begin
        bus.m0_valid = 0; bus.m1_valid = 0;
      end
      tick();
      bus.s_ready = 0;
      #1;
      chk($sformatf("rr_idle_grant_%0d", i), {30'd0, grant}, 32'd0);
    end

    // m1 instruction-flagged partial write
    bus.m1_valid = 1; bus.m1_instr = 1; bus.m1_addr = 32'h40;
    bus.m1_wdata = 32'hCAFEF00D; bus.m1_wstrb = 4'b0011;
    tick();
    chk("wr_grant", {30'd0, grant}, 32'd2);
    chk("wr_s_wdata", bus.s_wdata, 32'hCAFEF00D);
    chk("wr_s_wstrb", {28'd0, bus.s_wstrb}, 32'h3);
    chk("wr_s_addr", bus.s_addr, 32'h40);
    chk("wr_s_instr", {31'd0, bus.s_instr}, 32'd1);
    chk("wr_m1_ready_low", {31'd0, bus.m1_ready}, 32'd0);
    bus.s_ready = 1;
    #1;
    chk("wr_m1_ready", {31'd0, bus.m1_ready}, 32'd1);
    chk("wr_m0_ready", {31'd0, bus.m0_ready}, 32'd0);
    bus.m1_valid = 0; bus.m1_instr = 0; bus.m1_wstrb = 0;
    tick();
    bus.s_ready = 0;

    // m0 read, slave never answers: timeout on the eighth BUSY cycle
    bus.m0_valid = 1; bus.m0_addr = 32'h500; bus.s_rdata = 32'h55;
    tick();
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("to_wait_ready_%0d", i), {31'd0, bus.m0_ready}, 32'd0);
      chk($sformatf("to_wait_err_%0d", i), {31'd0, timeout_err}, 32'd0);
      tick();
    end
    chk("to_m0_ready", {31'd0, bus.m0_ready}, 32'd1);
    chk("to_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    bus.m0_valid = 0;
    tick();
    chk("to_err_once", {31'd0, timeout_err}, 32'd0);
    chk("to_grant_clear", {30'd0, grant}, 32'd0);

    // s_ready on the last allowed cycle wins over the timeout; m0 drops valid mid-transfer
    bus.m0_valid = 1;
    tick();
    bus.m0_valid = 0;
    for (int i = 1; i < 8; i++) tick();
    chk("edge_still_busy", {31'd0, bus.s_valid}, 32'd1);
    bus.s_ready = 1; bus.s_rdata = 32'hA5A50042;
    #1;
    chk("edge_m0_ready", {31'd0, bus.m0_ready}, 32'd1);
    chk("edge_m0_rdata", bus.m0_rdata, 32'hA5A50042);
    chk("edge_no_err", {31'd0, timeout_err}, 32'd0);
    tick();
    bus.s_ready = 0;

    // Reset mid-BUSY: pointer favours m1 here, reset returns priority to m0
    bus.m0_valid = 1; bus.m0_addr = 32'h600;
    bus.m1_valid = 1; bus.m1_addr = 32'h700;
    tick();
    chk("mid_grant_m1", {30'd0, grant}, 32'd2);
    bus.s_ready = 1;
    reset = 1'b1;
    #1;
    chk("mid_rst_s_valid", {31'd0, bus.s_valid}, 32'd0);
    chk("mid_rst_grant", {30'd0, grant}, 32'd0);
    chk("mid_rst_m1_ready", {31'd0, bus.m1_ready}, 32'd0);
    chk("mid_rst_m0_ready", {31'd0, bus.m0_ready}, 32'd0);
    tick();
    reset = 1'b0;
    bus.s_ready = 0;
    tick();
    chk("post_rst_grant_m0", {30'd0, grant}, 32'd1);
    chk("post_rst_s_addr", bus.s_addr, 32'h600);
    bus.s_ready = 1; bus.s_rdata = 32'h77;
    #1;
    chk("post_rst_m0_ready", {31'd0, bus.m0_ready}, 32'd1);
    bus.m0_valid = 0; bus.m1_valid = 0;
    tick();
    bus.s_ready = 0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
